// File: rtl/chacha20_poly1305_pkg.sv
// Shared definitions for the ChaCha20/Poly1305 register-bus block:
// bus widths, register addresses, CTRL/STATUS bit positions, the ChaCha
// "expand 32-byte k" constants, FSM and command enums, and word helpers.
package chacha20_poly1305_pkg;

   localparam int unsigned ADDR_W      = 8;
   localparam int unsigned DATA_W      = 512;
   localparam int unsigned WORD_W      = 32;
   localparam int unsigned KEY_W       = 256;
   localparam int unsigned NONCE_W     = 96;
   localparam int unsigned POLYKEY_W   = 256;
   localparam int unsigned STATUS_W    = 7;

   localparam logic [ADDR_W-1:0] ADDR_CTRL    = 8'h08;
   localparam logic [ADDR_W-1:0] ADDR_STATUS  = 8'h09;
   localparam logic [ADDR_W-1:0] ADDR_KEY     = 8'h10;
   localparam logic [ADDR_W-1:0] ADDR_NONCE   = 8'h20;
   localparam logic [ADDR_W-1:0] ADDR_DATA    = 8'h30;
   localparam logic [ADDR_W-1:0] ADDR_RESULT  = 8'h31;
   localparam logic [ADDR_W-1:0] ADDR_POLYKEY = 8'h40;

   localparam int unsigned CTRL_INIT = 0;
   localparam int unsigned CTRL_NEXT = 1;
   localparam int unsigned CTRL_DONE = 2;

   localparam int unsigned ST_READY         = 0;
   localparam int unsigned ST_RESULT_VALID  = 1;
   localparam int unsigned ST_POLYKEY_VALID = 2;
   localparam int unsigned ST_DONE_FLAG     = 3;
   localparam int unsigned ST_PENDING       = 4;
   localparam int unsigned ST_ERR           = 5;
   localparam int unsigned ST_CTR_WRAP      = 6;

   localparam logic [WORD_W-1:0] SIGMA0 = 32'h61707865;
   localparam logic [WORD_W-1:0] SIGMA1 = 32'h3320646e;
   localparam logic [WORD_W-1:0] SIGMA2 = 32'h79622d32;
   localparam logic [WORD_W-1:0] SIGMA3 = 32'h6b206574;

   // Word k of the ChaCha state sits at bits [32k+31:32k].
   typedef logic [15:0][WORD_W-1:0] cc_state_t;

   typedef enum logic [1:0] {
      FSM_IDLE,
      FSM_LOAD,
      FSM_ROUNDS,
      FSM_FINAL
   } fsm_e;

   typedef enum logic [1:0] {
      CMD_NONE,
      CMD_INIT,
      CMD_NEXT,
      CMD_DONE
   } cmd_e;

   function automatic logic [WORD_W-1:0] rotl32(input logic [WORD_W-1:0] x,
                                                input int unsigned n);
      return (x << n) | (x >> (WORD_W - n));
   endfunction

   // Per-word modulo 2^32 addition of two states.
   function automatic cc_state_t add_state(input cc_state_t a, input cc_state_t b);
      cc_state_t s;
      for (int k = 0; k < 16; k++) begin
         s[k] = a[k] + b[k];
      end
      return s;
   endfunction

endpackage

// File: rtl/chacha20_poly1305_bus_if.sv
// Single-cycle 512-bit register bus.
//   cs, we, address, write_data : host -> block
//   read_data                   : block -> host, registered in the block
interface chacha20_poly1305_bus_if;
   import chacha20_poly1305_pkg::*;

   logic              cs;
   logic              we;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] write_data;
   logic [DATA_W-1:0] read_data;

   modport master (output cs, we, address, write_data, input read_data);
   modport slave  (input cs, we, address, write_data, output read_data);

endinterface

// File: rtl/chacha20_qr.sv
// ChaCha20 quarter-round, purely combinational.
//   a_i..d_i : input words
//   a_c..d_c : output words
module chacha20_qr
   import chacha20_poly1305_pkg::*;
(
   input  logic [WORD_W-1:0] a_i,
   input  logic [WORD_W-1:0] b_i,
   input  logic [WORD_W-1:0] c_i,
   input  logic [WORD_W-1:0] d_i,
   output logic [WORD_W-1:0] a_c,
   output logic [WORD_W-1:0] b_c,
   output logic [WORD_W-1:0] c_c,
   output logic [WORD_W-1:0] d_c
);

   logic [WORD_W-1:0] a1, b1, c1, d1;

   assign a1  = a_i + b_i;
   assign d1  = rotl32(d_i ^ a1, 16);
   assign c1  = c_i + d1;
   assign b1  = rotl32(b_i ^ c1, 12);
   assign a_c = a1 + b1;
   assign d_c = rotl32(d1 ^ a_c, 8);
   assign c_c = c1 + d_c;
   assign b_c = rotl32(b1 ^ c_c, 7);

endmodule

// File: rtl/chacha20_poly1305_bus.sv
// Register-mapped iterative ChaCha20 block function for an AEAD datapath.
// init derives the Poly1305 one-time key from block 0; next XORs DATA with
// the keystream for counters 1, 2, ...; done clears the results.
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : register bus slave (cs/we/address/write_data in, read_data out)
// Option: CC20P_ZEROIZE_EN -- done also clears KEY, NONCE and DATA and
// forces a new init before the next block.
module chacha20_poly1305_bus
   import chacha20_poly1305_pkg::*;
#(
   parameter int unsigned NUM_DOUBLE_ROUNDS = 10
)(
   input  logic                   clk,
   input  logic                   reset_n,
   chacha20_poly1305_bus_if.slave bus
);

   localparam int unsigned ROUND_W = $clog2(NUM_DOUBLE_ROUNDS + 1);

   fsm_e                 state_q, state_d;
   cmd_e                 cur_cmd_q, cur_cmd_d;
   cmd_e                 pend_q, pend_d;
   logic [KEY_W-1:0]     key_q, key_d;
   logic [NONCE_W-1:0]   nonce_q, nonce_d;
   logic [DATA_W-1:0]    data_q, data_d;
   logic [DATA_W-1:0]    data_snap_q, data_snap_d;
   logic [DATA_W-1:0]    result_q, result_d;
   logic [POLYKEY_W-1:0] polykey_q, polykey_d;
   logic [WORD_W-1:0]    counter_q, counter_d;
   cc_state_t            x_q, x_d;
   cc_state_t            in_q, in_d;
   logic [ROUND_W-1:0]   round_q, round_d;
   logic                 result_valid_q, result_valid_d;
   logic                 polykey_valid_q, polykey_valid_d;
   logic                 done_flag_q, done_flag_d;
   logic                 err_q, err_d;
   logic                 ctr_wrap_q, ctr_wrap_d;
   logic                 keyed_q, keyed_d;
   logic [DATA_W-1:0]    read_data_q, read_data_d;

   logic                 wr_c, rd_c;
   cmd_e                 cmd_new_c;
   cmd_e                 cmd_go_c;
   logic                 err_set_c, err_clr_c;
   logic [WORD_W-1:0]    ctr_load_c;
   cc_state_t            init_c, col_c, dround_c, blk_c;
   logic [STATUS_W-1:0]  status_c;

   assign wr_c = bus.cs & bus.we;
   assign rd_c = bus.cs & ~bus.we;
   assign bus.read_data = read_data_q;

   // CTRL decode, init > next > done.
   always_comb begin
      cmd_new_c = CMD_NONE;
      if (wr_c && (bus.address == ADDR_CTRL)) begin
         if (bus.write_data[CTRL_INIT])      cmd_new_c = CMD_INIT;
         else if (bus.write_data[CTRL_NEXT]) cmd_new_c = CMD_NEXT;
         else if (bus.write_data[CTRL_DONE]) cmd_new_c = CMD_DONE;
      end
   end

   // Block input: counter restarts at 0 for init, else pre-increments.
   assign ctr_load_c = (cur_cmd_q == CMD_INIT) ? '0 : counter_q + 32'd1;
   assign init_c     = {nonce_q, ctr_load_c, key_q, SIGMA3, SIGMA2, SIGMA1, SIGMA0};
   assign blk_c      = add_state(x_q, in_q);

   // One double round per cycle: column pass feeds diagonal pass.
   for (genvar i = 0; i < 4; i++) begin : g_qr
      localparam int unsigned DB = 4  + ((i + 1) % 4);
      localparam int unsigned DC = 8  + ((i + 2) % 4);
      localparam int unsigned DD = 12 + ((i + 3) % 4);

      chacha20_qr u_col (
         .a_i (x_q[i]),     .b_i (x_q[4+i]),   .c_i (x_q[8+i]),   .d_i (x_q[12+i]),
         .a_c (col_c[i]),   .b_c (col_c[4+i]), .c_c (col_c[8+i]), .d_c (col_c[12+i])
      );

      chacha20_qr u_diag (
         .a_i (col_c[i]),    .b_i (col_c[DB]),    .c_i (col_c[DC]),    .d_i (col_c[DD]),
         .a_c (dround_c[i]), .b_c (dround_c[DB]), .c_c (dround_c[DC]), .d_c (dround_c[DD])
      );
   end

   always_comb begin
      status_c                   = '0;
      status_c[ST_READY]         = (state_q == FSM_IDLE) && (pend_q == CMD_NONE);
      status_c[ST_RESULT_VALID]  = result_valid_q;
      status_c[ST_POLYKEY_VALID] = polykey_valid_q;
      status_c[ST_DONE_FLAG]     = done_flag_q;
      status_c[ST_PENDING]       = (pend_q != CMD_NONE);
      status_c[ST_ERR]           = err_q;
      status_c[ST_CTR_WRAP]      = ctr_wrap_q;
   end

   // Next-state: command launch, bus writes, FSM datapath, read mux.
   always_comb begin
      state_d         = state_q;
      cur_cmd_d       = cur_cmd_q;
      pend_d          = pend_q;
      key_d           = key_q;
      nonce_d         = nonce_q;
      data_d          = data_q;
      data_snap_d     = data_snap_q;
      result_d        = result_q;
      polykey_d       = polykey_q;
      counter_d       = counter_q;
      x_d             = x_q;
      in_d            = in_q;
      round_d         = round_q;
      result_valid_d  = result_valid_q;
      polykey_valid_d = polykey_valid_q;
      done_flag_d     = done_flag_q;
      ctr_wrap_d      = ctr_wrap_q;
      keyed_d         = keyed_q;
      read_data_d     = read_data_q;
      cmd_go_c        = CMD_NONE;
      err_set_c       = 1'b0;
      err_clr_c       = 1'b0;

      // Pending slot: drained first when idle, one deep while busy.
      if (state_q == FSM_IDLE) begin
         if (pend_q != CMD_NONE) begin
            cmd_go_c = pend_q;
            pend_d   = cmd_new_c;
         end else begin
            cmd_go_c = cmd_new_c;
         end
      end else if (cmd_new_c != CMD_NONE) begin
         if (pend_q == CMD_NONE) pend_d    = cmd_new_c;
         else                    err_set_c = 1'b1;
      end

      case (cmd_go_c)
         CMD_INIT: begin
            state_d   = FSM_LOAD;
            cur_cmd_d = CMD_INIT;
            err_clr_c = 1'b1;
         end
         CMD_NEXT: begin
            if (keyed_q) begin
               state_d   = FSM_LOAD;
               cur_cmd_d = CMD_NEXT;
            end else begin
               err_set_c = 1'b1;
            end
         end
         CMD_DONE: begin
            result_valid_d  = 1'b0;
            polykey_valid_d = 1'b0;
            result_d        = '0;
            polykey_d       = '0;
            done_flag_d     = 1'b1;
`ifdef CC20P_ZEROIZE_EN
            key_d   = '0;
            nonce_d = '0;
            data_d  = '0;
            keyed_d = 1'b0;
`endif
         end
         default: ;
      endcase

      // Host writes land immediately, even mid-block.
      if (wr_c) begin
         case (bus.address)
            ADDR_KEY:    key_d   = bus.write_data[KEY_W-1:0];
            ADDR_NONCE:  nonce_d = bus.write_data[NONCE_W-1:0];
            ADDR_DATA:   data_d  = bus.write_data;
            ADDR_CTRL, ADDR_STATUS, ADDR_RESULT, ADDR_POLYKEY: ;
            default:     err_set_c = 1'b1;
         endcase
      end

      case (state_q)
         FSM_LOAD: begin
            counter_d   = ctr_load_c;
            if ((cur_cmd_q == CMD_NEXT) && (counter_q == 32'hFFFF_FFFF)) ctr_wrap_d = 1'b1;
            in_d        = init_c;
            x_d         = init_c;
            data_snap_d = data_q;
            round_d     = '0;
            state_d     = FSM_ROUNDS;
         end
         FSM_ROUNDS: begin
            x_d     = dround_c;
            round_d = round_q + ROUND_W'(1);
            if (round_q == ROUND_W'(NUM_DOUBLE_ROUNDS - 1)) state_d = FSM_FINAL;
         end
         FSM_FINAL: begin
            state_d = FSM_IDLE;
            if (cur_cmd_q == CMD_INIT) begin
               polykey_d       = blk_c[7:0];
               polykey_valid_d = 1'b1;
               result_valid_d  = 1'b0;
               done_flag_d     = 1'b0;
               ctr_wrap_d      = 1'b0;
               keyed_d         = 1'b1;
            end else begin
               result_d       = data_snap_q ^ blk_c;
               result_valid_d = 1'b1;
            end
         end
         default: ;
      endcase

      err_d = (err_q & ~err_clr_c) | err_set_c;

      if (rd_c) begin
         case (bus.address)
            ADDR_STATUS:  read_data_d = DATA_W'(status_c);
            ADDR_RESULT:  read_data_d = result_q;
            ADDR_POLYKEY: read_data_d = DATA_W'(polykey_q);
            default:      read_data_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= FSM_IDLE;
         cur_cmd_q       <= CMD_NONE;
         pend_q          <= CMD_NONE;
         key_q           <= '0;
         nonce_q         <= '0;
         data_q          <= '0;
         data_snap_q     <= '0;
         result_q        <= '0;
         polykey_q       <= '0;
         counter_q       <= '0;
         x_q             <= '0;
         in_q            <= '0;
         round_q         <= '0;
         result_valid_q  <= 1'b0;
         polykey_valid_q <= 1'b0;
         done_flag_q     <= 1'b0;
         err_q           <= 1'b0;
         ctr_wrap_q      <= 1'b0;
         keyed_q         <= 1'b0;
         read_data_q     <= '0;
      end else begin
         state_q         <= state_d;
         cur_cmd_q       <= cur_cmd_d;
         pend_q          <= pend_d;
         key_q           <= key_d;
         nonce_q         <= nonce_d;
         data_q          <= data_d;
         data_snap_q     <= data_snap_d;
         result_q        <= result_d;
         polykey_q       <= polykey_d;
         counter_q       <= counter_d;
         x_q             <= x_d;
         in_q            <= in_d;
         round_q         <= round_d;
         result_valid_q  <= result_valid_d;
         polykey_valid_q <= polykey_valid_d;
         done_flag_q     <= done_flag_d;
         err_q           <= err_d;
         ctr_wrap_q      <= ctr_wrap_d;
         keyed_q         <= keyed_d;
         read_data_q     <= read_data_d;
      end
   end

endmodule

// File: tb/tb_chacha20_poly1305_bus.sv
// Directed bench for chacha20_poly1305_bus using RFC 8439 vectors and
// hand-derived STATUS values.
module tb_chacha20_poly1305_bus;
   import chacha20_poly1305_pkg::*;

   logic clk;
   logic reset_n;
   int   n_checks;
   int   n_fail;
   logic [511:0] rd;

   chacha20_poly1305_bus_if bus_if ();

   chacha20_poly1305_bus #(.NUM_DOUBLE_ROUNDS(10)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Each access occupies exactly the next rising edge; called at a falling edge.
   task automatic bus_write(input logic [7:0] a, input logic [511:0] d);
      bus_if.cs         = 1'b1;
      bus_if.we         = 1'b1;
      bus_if.address    = a;
      bus_if.write_data = d;
      @(negedge clk);
      bus_if.cs = 1'b0;
      bus_if.we = 1'b0;
   endtask

   task automatic bus_read(input logic [7:0] a, output logic [511:0] d);
      bus_if.cs      = 1'b1;
      bus_if.we      = 1'b0;
      bus_if.address = a;
      @(negedge clk);
      bus_if.cs = 1'b0;
      d = bus_if.read_data;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Key bytes base, base+1, ... packed little-endian per word.
   function automatic logic [511:0] make_key(input logic [7:0] base);
      logic [511:0] k;
      k = '0;
      for (int i = 0; i < 32; i++) k[8*i +: 8] = base + 8'(i);
      return k;
   endfunction

   initial begin
      n_checks          = 0;
      n_fail            = 0;
      reset_n           = 1'b0;
      bus_if.cs         = 1'b0;
      bus_if.we         = 1'b0;
      bus_if.address    = '0;
      bus_if.write_data = '0;

      // Reset
      idle(2);
      bus_read(ADDR_STATUS, rd);
      check("status_in_reset", rd, 512'h0);
      reset_n = 1'b1;
      bus_read(ADDR_STATUS, rd);
      check("status_after_reset", rd, 512'h1);

      // RFC 8439 2.3.2 block, counter 1
      bus_write(ADDR_KEY, make_key(8'h00));
      bus_write(ADDR_NONCE, {416'h0, 32'h00000000, 32'h4a000000, 32'h09000000});
      bus_write(ADDR_DATA, 512'h0);
      bus_write(ADDR_CTRL, 512'h1);
      idle(12);
      bus_write(ADDR_CTRL, 512'h2);
      idle(12);
      bus_read(ADDR_RESULT, rd);
      check("rfc232_word0", 512'(rd[31:0]), 512'he4e7f110);
      check("rfc232_word15", 512'(rd[511:480]), 512'h4e3c50a2);
      bus_read(ADDR_STATUS, rd);
      check("rfc232_status", rd, 512'h7);

      // RFC 8439 2.6.2 Poly1305 key generation
      bus_write(ADDR_KEY, make_key(8'h80));
      bus_write(ADDR_NONCE, {416'h0, 32'h07060504, 32'h03020100, 32'h00000000});
      bus_write(ADDR_CTRL, 512'h1);
      idle(12);
      bus_read(ADDR_POLYKEY, rd);
      check("polykey_word0", 512'(rd[31:0]), 512'h8ba0d58a);
      check("polykey_word7", 512'(rd[255:224]), 512'h46a6d1fd);
      check("polykey_upper", 512'(rd[511:256]), 512'h0);
      bus_read(ADDR_STATUS, rd);
      check("polykey_status", rd, 512'h5);

      // Back-to-back: init, next pending, done dropped
      bus_write(ADDR_CTRL, 512'h1);
      idle(1);
      bus_write(ADDR_CTRL, 512'h2);
      bus_read(ADDR_STATUS, rd);
      check("b2b_pending", rd, 512'h14);
      bus_write(ADDR_CTRL, 512'h4);
      bus_read(ADDR_STATUS, rd);
      check("b2b_dropped_err", rd, 512'h34);
      idle(30);
      bus_read(ADDR_STATUS, rd);
      check("b2b_settled", rd, 512'h27);

      // Done from idle after a valid next
      bus_write(ADDR_CTRL, 512'h1);
      idle(12);
      bus_write(ADDR_CTRL, 512'h2);
      idle(12);
      bus_read(ADDR_STATUS, rd);
      check("pre_done_status", rd, 512'h7);
      bus_write(ADDR_CTRL, 512'h4);
      bus_read(ADDR_RESULT, rd);
      check("done_result_zero", rd, 512'h0);
      bus_read(ADDR_POLYKEY, rd);
      check("done_polykey_zero", rd, 512'h0);
      bus_read(ADDR_STATUS, rd);
      check("done_status", rd, 512'h9);

      // CTRL priority: next beats done, init beats both
      bus_write(ADDR_CTRL, 512'h6);
      idle(12);
      bus_read(ADDR_STATUS, rd);
      check("prio_next_over_done", rd, 512'hb);
      bus_write(ADDR_CTRL, 512'h7);
      idle(12);
      bus_read(ADDR_STATUS, rd);
      check("prio_init_first", rd, 512'h5);

      // Bus edges
      bus_read(ADDR_KEY, rd);
      check("key_reads_zero", rd, 512'h0);
      bus_read(8'h55, rd);
      check("unmapped_reads_zero", rd, 512'h0);
      bus_write(8'h55, 512'h1234);
      bus_read(ADDR_STATUS, rd);
      check("unmapped_write_err", rd, 512'h25);

      // Next before any init
      reset_n = 1'b0;
      idle(2);
      reset_n = 1'b1;
      bus_write(ADDR_DATA, {16{32'hdeadbeef}});
      bus_write(ADDR_CTRL, 512'h2);
      idle(12);
      bus_read(ADDR_RESULT, rd);
      check("next_no_init_result", rd, 512'h0);
      bus_read(ADDR_STATUS, rd);
      check("next_no_init_status", rd, 512'h21);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
